// File: rtl/scnn_wt_streamer_if.sv
// scnn_wt_streamer_if
//   Bundles the capture, handshake and output bus of the SCNN weight
//   streamer. clk and reset are kept as plain ports on the streamer.
//   Signals:
//     load      capture request from the compression stage
//     non_zero  number of compressed weights (clamped to 25 by the streamer)
//     comp_arr  packed non-zero weights, slot 0 first
//     comp_ind  zero-run length preceding each packed weight
//     replay    re-stream the latched buffer (only honoured when built in)
//     wt_ready  downstream PE accepts the presented element
//     wt_valid  element outputs are valid
//     wt_out / ind_out / pos_out / row_out / col_out / last  element fields
//     busy      streamer is not idle
//     done      single-cycle completion pulse
//   Modports: master = producer/consumer side (testbench or parent),
//             slave  = the streamer itself.
interface scnn_wt_streamer_if;
   logic              load;
   logic [7:0]        non_zero;
   logic [24:0][15:0] comp_arr;
   logic [24:0][7:0]  comp_ind;
   logic              replay;
   logic              wt_ready;
   logic              wt_valid;
   logic [15:0]       wt_out;
   logic [7:0]        ind_out;
   logic [4:0]        pos_out;
   logic [2:0]        row_out;
   logic [2:0]        col_out;
   logic              last;
   logic              busy;
   logic              done;

   modport master (
      output load, non_zero, comp_arr, comp_ind, replay, wt_ready,
      input  wt_valid, wt_out, ind_out, pos_out, row_out, col_out, last, busy, done
   );

   modport slave (
      input  load, non_zero, comp_arr, comp_ind, replay, wt_ready,
      output wt_valid, wt_out, ind_out, pos_out, row_out, col_out, last, busy, done
   );
endinterface

// File: rtl/scnn_wt_streamer.sv
// scnn_wt_streamer
//   Latches a compressed 5x5 kernel (up to 25 non-zero weights plus their
//   zero-run lengths) and streams it one element per cycle over a
//   valid/ready handshake, reconstructing each weight's raster position
//   (saturating at 24) and its row/column inside the kernel.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-high reset
//     bus    scnn_wt_streamer_if.slave (capture inputs, handshake, outputs)
//   All outputs are registered. busy is high in STREAM and DONE; done
//   pulses for one cycle in DONE.
//   Build option: define SCNN_WT_STREAM_REPLAY_EN to let replay=1 in IDLE
//   re-stream the latched buffer (load wins when both are high). Without it
//   the replay input is ignored and no replay logic exists.
module scnn_wt_streamer (
   input  logic              clk,
   input  logic              reset,
   scnn_wt_streamer_if.slave bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   localparam logic [4:0] MAX_CNT = 5'd25;
   localparam logic [4:0] MAX_POS = 5'd24;

   // Clamp a running index sum to the last kernel position.
   function automatic logic [4:0] sat_pos(input logic [9:0] sum);
      logic [4:0] res;
      if (sum > 10'd24) begin
         res = MAX_POS;
      end else begin
         res = sum[4:0];
      end
      return res;
   endfunction

   // Split a raster position (0..24) into {row[2:0], col[2:0]}. The column
   // fits in 3 bits, so pos - 5*row is exact when done modulo 8.
   function automatic logic [5:0] pos_rc(input logic [4:0] pos);
      logic [2:0] row;
      if (pos >= 5'd20) begin
         row = 3'd4;
      end else if (pos >= 5'd15) begin
         row = 3'd3;
      end else if (pos >= 5'd10) begin
         row = 3'd2;
      end else if (pos >= 5'd5) begin
         row = 3'd1;
      end else begin
         row = 3'd0;
      end
      return {row, pos[2:0] - (row * 3'd5)};
   endfunction

   logic [1:0]        state_q,    state_d;
   logic [24:0][15:0] arr_q,      arr_d;
   logic [24:0][7:0]  ind_q,      ind_d;
   logic [4:0]        cnt_q,      cnt_d;
   logic [4:0]        idx_q,      idx_d;
   logic              wt_valid_q, wt_valid_d;
   logic [15:0]       wt_q,       wt_d;
   logic [7:0]        ind_out_q,  ind_out_d;
   logic [4:0]        pos_q,      pos_d;
   logic [2:0]        row_q,      row_d;
   logic [2:0]        col_q,      col_d;
   logic              last_q,     last_d;
   logic              busy_q,     busy_d;
   logic              done_q,     done_d;

   logic              start_s;
   logic [24:0][15:0] src_arr_s;
   logic [24:0][7:0]  src_ind_s;
   logic [4:0]        src_cnt_s;
   logic [4:0]        load_cnt_s;
   logic [4:0]        start_pos_s;
   logic [5:0]        start_rc_s;
   logic [4:0]        next_idx_s;
   logic [9:0]        next_sum_s;
   logic [4:0]        next_pos_s;
   logic [5:0]        next_rc_s;

   // Element count for a fresh capture, clamped to the kernel size.
   assign load_cnt_s = (bus.non_zero > 8'd25) ? MAX_CNT : bus.non_zero[4:0];

`ifdef SCNN_WT_STREAM_REPLAY_EN
   // Select the buffer a new stream starts from: fresh inputs on load, else the latched copy on replay.
   always_comb begin
      start_s   = 1'b0;
      src_arr_s = bus.comp_arr;
      src_ind_s = bus.comp_ind;
      src_cnt_s = load_cnt_s;
      if (bus.load) begin
         start_s = 1'b1;
      end else if (bus.replay) begin
         start_s   = 1'b1;
         src_arr_s = arr_q;
         src_ind_s = ind_q;
         src_cnt_s = cnt_q;
      end else begin
         start_s = 1'b0;
      end
   end
`else
   logic replay_unused_s;
   assign replay_unused_s = bus.replay;

   // A new stream can only start from a fresh capture.
   always_comb begin
      start_s   = 1'b0;
      src_arr_s = bus.comp_arr;
      src_ind_s = bus.comp_ind;
      src_cnt_s = load_cnt_s;
      if (bus.load) begin
         start_s = 1'b1;
      end else begin
         start_s = 1'b0;
      end
   end
`endif

   // Element 0 sits at its own zero-run length; later elements advance by run+1.
   assign start_pos_s = sat_pos({2'b00, src_ind_s[0]});
   assign start_rc_s  = pos_rc(start_pos_s);
   assign next_idx_s  = idx_q + 5'd1;
   assign next_sum_s  = {5'd0, pos_q} + {2'd0, ind_q[next_idx_s]} + 10'd1;
   assign next_pos_s  = sat_pos(next_sum_s);
   assign next_rc_s   = pos_rc(next_pos_s);

   // FSM next state and next values of every registered output.
   always_comb begin
      state_d    = state_q;
      arr_d      = arr_q;
      ind_d      = ind_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      wt_valid_d = wt_valid_q;
      wt_d       = wt_q;
      ind_out_d  = ind_out_q;
      pos_d      = pos_q;
      row_d      = row_q;
      col_d      = col_q;
      last_d     = last_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            wt_valid_d = 1'b0;
            last_d     = 1'b0;
            if (start_s) begin
               arr_d = src_arr_s;
               ind_d = src_ind_s;
               cnt_d = src_cnt_s;
               if (src_cnt_s != 5'd0) begin
                  state_d    = ST_STREAM;
                  idx_d      = 5'd0;
                  wt_valid_d = 1'b1;
                  wt_d       = src_arr_s[0];
                  ind_out_d  = src_ind_s[0];
                  pos_d      = start_pos_s;
                  row_d      = start_rc_s[5:3];
                  col_d      = start_rc_s[2:0];
                  last_d     = (src_cnt_s == 5'd1);
               end else begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_STREAM: begin
            if (bus.wt_ready) begin
               if (last_q) begin
                  state_d    = ST_DONE;
                  wt_valid_d = 1'b0;
                  last_d     = 1'b0;
                  done_d     = 1'b1;
               end else begin
                  idx_d     = next_idx_s;
                  wt_d      = arr_q[next_idx_s];
                  ind_out_d = ind_q[next_idx_s];
                  pos_d     = next_pos_s;
                  row_d     = next_rc_s[5:3];
                  col_d     = next_rc_s[2:0];
                  last_d    = (next_idx_s == (cnt_q - 5'd1));
               end
            end else begin
               state_d = ST_STREAM;
            end
         end
         ST_DONE: begin
            state_d    = ST_IDLE;
            wt_valid_d = 1'b0;
            last_d     = 1'b0;
         end
         default: begin
            state_d    = ST_IDLE;
            wt_valid_d = 1'b0;
            last_d     = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         arr_q      <= '0;
         ind_q      <= '0;
         cnt_q      <= 5'd0;
         idx_q      <= 5'd0;
         wt_valid_q <= 1'b0;
         wt_q       <= 16'd0;
         ind_out_q  <= 8'd0;
         pos_q      <= 5'd0;
         row_q      <= 3'd0;
         col_q      <= 3'd0;
         last_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         arr_q      <= arr_d;
         ind_q      <= ind_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         wt_valid_q <= wt_valid_d;
         wt_q       <= wt_d;
         ind_out_q  <= ind_out_d;
         pos_q      <= pos_d;
         row_q      <= row_d;
         col_q      <= col_d;
         last_q     <= last_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.wt_valid = wt_valid_q;
   assign bus.wt_out   = wt_q;
   assign bus.ind_out  = ind_out_q;
   assign bus.pos_out  = pos_q;
   assign bus.row_out  = row_q;
   assign bus.col_out  = col_q;
   assign bus.last     = last_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_scnn_wt_streamer.sv
// tb_scnn_wt_streamer
//   Self-checking bench for scnn_wt_streamer: a table of first-element
//   vectors, hand-written sequences for the timing corner cases, and a
//   randomized run compared against a list-based reference model.
module tb_scnn_wt_streamer;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   scnn_wt_streamer_if bus ();

   scnn_wt_streamer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Reference data: what was loaded, and the element list it should produce.
   logic [15:0] m_arr [25];
   logic [7:0]  m_ind [25];
   int          m_nz;
   int          exp_n;
   logic [15:0] exp_w [25];
   logic [7:0]  exp_i [25];
   int          exp_pos [25];

   typedef struct {
      int          nz;
      logic [15:0] w0;
      logic [7:0]  i0;
      bit          ev;
      int          epos;
      int          erow;
      int          ecol;
      bit          elast;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Element list from the rules: clamp count, running position sum, clamp at 24.
   task automatic build_model();
      int sum;
      exp_n = (m_nz > 25) ? 25 : m_nz;
      sum = 0;
      for (int k = 0; k < exp_n; k++) begin
         if (k == 0) sum = int'(m_ind[0]);
         else        sum = sum + int'(m_ind[k]) + 1;
         exp_w[k]   = m_arr[k];
         exp_i[k]   = m_ind[k];
         exp_pos[k] = (sum > 24) ? 24 : sum;
      end
   endtask

   function automatic logic [35:0] exp_tuple(input int k);
      logic [4:0] p;
      logic [2:0] r;
      logic [2:0] c;
      p = 5'(exp_pos[k]);
      r = 3'(exp_pos[k] / 5);
      c = 3'(exp_pos[k] % 5);
      return {exp_w[k], exp_i[k], p, r, c, (k == exp_n - 1)};
   endfunction

   function automatic logic [35:0] act_tuple();
      return {bus.wt_out, bus.ind_out, bus.pos_out, bus.row_out, bus.col_out, bus.last};
   endfunction

   task automatic drive_bus();
      for (int k = 0; k < 25; k++) begin
         bus.comp_arr[k] = m_arr[k];
         bus.comp_ind[k] = m_ind[k];
      end
      bus.non_zero = 8'(m_nz);
   endtask

   task automatic do_load();
      drive_bus();
      build_model();
      bus.load = 1'b1;
      step();
      bus.load = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic set_req033();
      for (int k = 0; k < 25; k++) begin
         m_arr[k] = 16'h0;
         m_ind[k] = 8'h0;
      end
      m_arr[0] = 16'h0011; m_arr[1] = 16'h0022; m_arr[2] = 16'h0033;
      m_ind[0] = 8'd0;     m_ind[1] = 8'd5;     m_ind[2] = 8'd17;
      m_nz = 3;
   endtask

   // Follow one stream from its first presented cycle to the cycle after done.
   task automatic run_check(input int ready_pct, input int stall_elem, input int stall_len,
                            input int midload_at, output int cycles);
      int  k;
      int  stalls;
      int  e0;
      bit  fin;
      bit  r;
      k      = 0;
      stalls = stall_len;
      e0     = errors;
      fin    = 1'b0;
      cycles = 0;
      while (!fin && cycles < 600) begin
         bus.load = (cycles == midload_at);
         if (k < exp_n) begin
            check("valid", 64'(bus.wt_valid), 64'd1);
            check("busy", 64'(bus.busy), 64'd1);
            check("done_early", 64'(bus.done), 64'd0);
            check("elem", 64'(act_tuple()), 64'(exp_tuple(k)));
            if (errors != e0) begin
               fin = 1'b1;
            end else begin
               if (k == stall_elem && stalls > 0) begin
                  r = 1'b0;
                  stalls--;
               end else begin
                  r = (int'($urandom_range(99)) < ready_pct);
               end
               bus.wt_ready = r;
               if (r) k++;
            end
         end else begin
            check("valid_in_done", 64'(bus.wt_valid), 64'd0);
            check("done_pulse", 64'(bus.done), 64'd1);
            check("busy_in_done", 64'(bus.busy), 64'd1);
            fin = 1'b1;
         end
         step();
         cycles++;
      end
      bus.load     = 1'b0;
      bus.wt_ready = 1'b1;
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL stream_timeout actual=%0d transfers expected=%0d", k, exp_n);
      end
      if (errors == e0) begin
         check("done_single", 64'(bus.done), 64'd0);
         check("busy_after", 64'(bus.busy), 64'd0);
         check("valid_after", 64'(bus.wt_valid), 64'd0);
      end else begin
         do_reset();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int cyc;
      bus.load     = 1'b0;
      bus.replay   = 1'b0;
      bus.wt_ready = 1'b1;
      bus.non_zero = 8'd0;
      bus.comp_arr = '0;
      bus.comp_ind = '0;
      reset        = 1'b1;
      step();
      step();
      check("reset_outs", 64'({bus.wt_valid, bus.last, bus.busy, bus.done, bus.wt_out,
                                bus.ind_out, bus.pos_out, bus.row_out, bus.col_out}), 64'd0);
      reset = 1'b0;
      step();
      check("idle_busy", 64'(bus.busy), 64'd0);

      // Full throughput: pos 0,6,24, last on the third, done right after.
      set_req033();
      do_load();
      run_check(100, -1, 0, -1, cyc);
      check("req033_cycles", 64'(cyc), 64'd4);

`ifdef SCNN_WT_STREAM_REPLAY_EN
      bus.replay = 1'b1;
      step();
      bus.replay = 1'b0;
      run_check(100, -1, 0, -1, cyc);
      check("replay_cycles", 64'(cyc), 64'd4);
      for (int k = 0; k < 25; k++) begin
         m_arr[k] = 16'(16'h0100 + k);
         m_ind[k] = 8'd1;
      end
      m_nz = 4;
      drive_bus();
      build_model();
      bus.replay = 1'b1;
      bus.load   = 1'b1;
      step();
      bus.replay = 1'b0;
      bus.load   = 1'b0;
      run_check(100, -1, 0, -1, cyc);
      check("replay_load_cycles", 64'(cyc), 64'd5);
`else
      bus.replay = 1'b1;
      step();
      check("replay_ignored_busy", 64'(bus.busy), 64'd0);
      check("replay_ignored_valid", 64'(bus.wt_valid), 64'd0);
      bus.replay = 1'b0;
      step();
      check("replay_ignored_done", 64'(bus.done), 64'd0);
`endif

      // Backpressure: three stalled cycles on element 1.
      set_req033();
      do_load();
      run_check(100, 1, 3, -1, cyc);
      check("req035_cycles", 64'(cyc), 64'd7);

      // Zero count: straight to done, no valid cycle.
      m_nz = 0;
      do_load();
      run_check(100, -1, 0, -1, cyc);
      check("req034_cycles", 64'(cyc), 64'd1);

      // Saturation: 40 requested, 25 streamed at pos 0..24, mid-stream load ignored.
      for (int k = 0; k < 25; k++) begin
         m_arr[k] = 16'($urandom) | 16'h0001;
         m_ind[k] = 8'd0;
      end
      m_nz = 40;
      do_load();
      bus.non_zero = 8'd3;
      for (int k = 0; k < 25; k++) begin
         bus.comp_arr[k] = 16'hDEAD;
         bus.comp_ind[k] = 8'd9;
      end
      run_check(100, -1, 0, 5, cyc);
      check("req036_cycles", 64'(cyc), 64'd26);

      // Table: first presented element for a range of counts and leading runs.
      tbl[0] = '{1,   16'hABCD, 8'd0,   1'b1, 0,  0, 0, 1'b1};
      tbl[1] = '{1,   16'h1234, 8'd7,   1'b1, 7,  1, 2, 1'b1};
      tbl[2] = '{2,   16'h5555, 8'd24,  1'b1, 24, 4, 4, 1'b0};
      tbl[3] = '{5,   16'h0F0F, 8'd200, 1'b1, 24, 4, 4, 1'b0};
      tbl[4] = '{0,   16'h7777, 8'd3,   1'b0, 0,  0, 0, 1'b0};
      tbl[5] = '{30,  16'hBEEF, 8'd12,  1'b1, 12, 2, 2, 1'b0};
      tbl[6] = '{255, 16'hFFFF, 8'd3,   1'b1, 3,  0, 3, 1'b0};
      tbl[7] = '{25,  16'h0001, 8'd19,  1'b1, 19, 3, 4, 1'b0};
      for (int t = 0; t < 8; t++) begin
         for (int k = 0; k < 25; k++) begin
            m_arr[k] = 16'($urandom);
            m_ind[k] = 8'd0;
         end
         m_arr[0] = tbl[t].w0;
         m_ind[0] = tbl[t].i0;
         m_nz     = tbl[t].nz;
         do_load();
         check("tbl_valid", 64'(bus.wt_valid), 64'(tbl[t].ev));
         if (tbl[t].ev) begin
            check("tbl_wt", 64'(bus.wt_out), 64'(tbl[t].w0));
            check("tbl_pos", 64'(bus.pos_out), 64'(tbl[t].epos));
            check("tbl_row", 64'(bus.row_out), 64'(tbl[t].erow));
            check("tbl_col", 64'(bus.col_out), 64'(tbl[t].ecol));
            check("tbl_last", 64'(bus.last), 64'(tbl[t].elast));
         end else begin
            check("tbl_done", 64'(bus.done), 64'd1);
         end
         run_check(100, -1, 0, -1, cyc);
      end

      // Randomized streams with random backpressure.
      for (int it = 0; it < 40; it++) begin
         for (int k = 0; k < 25; k++) begin
            m_arr[k] = 16'($urandom);
            if ($urandom_range(7) == 0) m_ind[k] = 8'($urandom_range(255));
            else                        m_ind[k] = 8'($urandom_range(2));
         end
         if ($urandom_range(3) == 0) m_nz = int'($urandom_range(26, 255));
         else                        m_nz = int'($urandom_range(0, 25));
         do_load();
         run_check(int'($urandom_range(40, 100)), -1, 0, -1, cyc);
         if ($urandom_range(1) == 1) step();
      end

      // Reset during the second transfer: everything cleared, no done pulse.
      set_req033();
      do_load();
      build_model();
      bus.wt_ready = 1'b1;
      step();
      check("rst_elem1", 64'(act_tuple()), 64'(exp_tuple(1)));
      reset = 1'b1;
      step();
      check("rst_outs", 64'({bus.wt_valid, bus.last, bus.busy, bus.done, bus.wt_out,
                              bus.ind_out, bus.pos_out, bus.row_out, bus.col_out}), 64'd0);
      reset = 1'b0;
      step();
      check("rst_idle_busy", 64'(bus.busy), 64'd0);
      check("rst_no_done", 64'(bus.done), 64'd0);
      check("rst_no_valid", 64'(bus.wt_valid), 64'd0);
      step();
      check("rst_no_done2", 64'(bus.done), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
